// File: rtl/led_blink_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler.
package led_blink_sched_pkg;

   // Scheduler phases; IDLE is encoded as zero so a reset register reads IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Width needed to hold an index in 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << w) < value) w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/led_blink_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... (mod N)
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] last_i,
   output logic [N-1:0]     grant_o,
   output logic [PTR_W-1:0] grant_idx_o,
   output logic             any_o
);

   logic [PTR_W-1:0] idx;

   // Walk the ring starting just after the previous winner; first hit wins.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      idx         = '0;
      for (int off = 1; off <= N; off++) begin
         idx = PTR_W'((int'(last_i) + off) % N);
         if (!any_o && req_i[idx]) begin
            any_o        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one LED blink engine among N_REQ requesters.
// Handshake: req_i[i] is a level held until grant_o[i] pulses for one cycle;
// done_o[i] pulses for one cycle when that burst (blinks plus gap) is over.
module led_blink_sched
   import led_blink_sched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int CNT_WIDTH = 16,
   parameter int BLINK_W   = 4
) (
   input  logic                       clk_i,
   input  logic                       arstn_i,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [N_REQ*BLINK_W-1:0]   blinks_i,
   input  logic [CNT_WIDTH-1:0]       half_period_i,
   output logic [N_REQ-1:0]           grant_o,
   output logic [N_REQ-1:0]           done_o,
   output logic                       busy_o,
   output logic                       led_o,
   output logic [1:0]                 dbg_state_o
);

   localparam int OWN_W = clog2(N_REQ);
   // One extra bit so the gap reload 2*hp+1 never wraps.
   localparam int TMR_W = CNT_WIDTH + 1;

   state_t             state, state_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic [BLINK_W-1:0] left, left_n;
   logic [OWN_W-1:0]   owner, owner_n;
   logic [CNT_WIDTH-1:0] hp, hp_n;
   logic [OWN_W-1:0]   last, last_n;
   logic               led_n;
   logic [N_REQ-1:0]   grant_n, done_n;

   logic [N_REQ-1:0]   arb_grant;
   logic [OWN_W-1:0]   arb_idx;
   logic               arb_any;
   logic [BLINK_W-1:0] sel_blinks;

   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (OWN_W)
   ) u_arb (
      .req_i       (req_i),
      .last_i      (last),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .any_o       (arb_any)
   );

   // Pick the blink count of the requester the arbiter is choosing now.
   always_comb begin
      sel_blinks = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) sel_blinks = blinks_i[i*BLINK_W +: BLINK_W];
      end
   end

   // Next-state, timer and output logic; everything holds unless changed.
   always_comb begin
      state_n = state;
      timer_n = timer;
      left_n  = left;
      owner_n = owner;
      hp_n    = hp;
      last_n  = last;
      led_n   = led_o;
      grant_n = '0;
      done_n  = '0;
      case (state)
         ST_IDLE: begin
            if (arb_any) begin
               owner_n = arb_idx;
               last_n  = arb_idx;
               hp_n    = half_period_i;
               left_n  = sel_blinks;
               grant_n = arb_grant;
               if (sel_blinks != '0) begin
                  state_n = ST_ON;
                  led_n   = 1'b1;
                  timer_n = {1'b0, half_period_i};
               end else begin
                  // Empty burst: straight to a full 2H gap with the LED dark.
                  state_n = ST_GAP;
                  led_n   = 1'b0;
                  timer_n = {half_period_i, 1'b1};
               end
            end
         end
         ST_ON: begin
            if (timer == '0) begin
               state_n = ST_OFF;
               led_n   = 1'b0;
               left_n  = left - BLINK_W'(1);
               timer_n = {1'b0, hp};
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         ST_OFF: begin
            if (timer == '0) begin
               if (left != '0) begin
                  state_n = ST_ON;
                  led_n   = 1'b1;
                  timer_n = {1'b0, hp};
               end else begin
                  state_n = ST_GAP;
                  timer_n = {hp, 1'b1};
               end
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         ST_GAP: begin
            if (timer == '0) begin
               state_n = ST_IDLE;
               done_n  = N_REQ'(1) << owner;
               timer_n = {hp, 1'b1};
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and registered outputs; async reset makes requester 0 win first.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state   <= ST_IDLE;
         timer   <= '0;
         left    <= '0;
         owner   <= '0;
         hp      <= '0;
         last    <= OWN_W'(N_REQ - 1);
         led_o   <= 1'b0;
         grant_o <= '0;
         done_o  <= '0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         left    <= left_n;
         owner   <= owner_n;
         hp      <= hp_n;
         last    <= last_n;
         led_o   <= led_n;
         grant_o <= grant_n;
         done_o  <= done_n;
      end
   end

   assign busy_o      = (state != ST_IDLE);
   assign dbg_state_o = state;

endmodule

// File: tb/tb_led_blink_sched.sv
// Scoreboard bench for led_blink_sched: a timed reference model predicts
// grant/done events and per-cycle LED/busy levels from each scenario.
module tb_led_blink_sched;
   import led_blink_sched_pkg::*;

   localparam int N    = 4;
   localparam int CW   = 4;
   localparam int BW   = 4;
   localparam int MAXC = 16384;
   localparam int EV_W = 37;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            arstn;
   logic [N-1:0]    req_i;
   logic [N*BW-1:0] blinks_i;
   logic [CW-1:0]   half_period_i;
   logic [N-1:0]    grant_o, done_o;
   logic            busy_o, led_o;
   logic [1:0]      dbg_state_o;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   led_blink_sched #(.N_REQ(N), .CNT_WIDTH(CW), .BLINK_W(BW)) dut (
      .clk_i         (clk),
      .arstn_i       (arstn),
      .req_i         (req_i),
      .blinks_i      (blinks_i),
      .half_period_i (half_period_i),
      .grant_o       (grant_o),
      .done_o        (done_o),
      .busy_o        (busy_o),
      .led_o         (led_o),
      .dbg_state_o   (dbg_state_o)
   );

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [EV_W-1:0] exp_q[$];
   logic led_exp  [MAXC];
   logic busy_exp [MAXC];

   // Model state: round-robin pointer and cycle at which the engine is free.
   int m_last;
   int m_free;
   int drop_cyc_q[$];
   logic [N-1:0] drop_clr_q[$];

   // Current scenario.
   logic [N-1:0] sc_mask;
   int sc_cnt[N];
   int sc_hp;
   bit sc_hold;
   int sc_ngr;

   function automatic logic [EV_W-1:0] mk_ev(input int c, input bit is_done, input logic [N-1:0] v);
      return {32'(c), is_done, v};
   endfunction

   // Predict the whole scenario given it is issued at the negedge of cycle 'issue'.
   task automatic plan(input int issue);
      int t, h, w, n, d, j, lim;
      logic [N-1:0] pend;
      pend = sc_mask;
      t    = issue + 1;
      h    = sc_hp + 1;
      lim  = sc_hold ? sc_ngr : N;
      for (int k = 0; k < lim; k++) begin
         if (pend != '0) begin
            w = -1;
            for (int off = 1; off <= N; off++) begin
               j = (m_last + off) % N;
               if (w < 0 && pend[j]) w = j;
            end
            m_last = w;
            n = sc_cnt[w];
            d = t + 2*n*h + 2*h;
            if (d >= MAXC - 4) begin
               $display("FAIL model_range cyc=%0d limit=%0d", d, MAXC);
               $fatal(1);
            end
            exp_q.push_back(mk_ev(t, 1'b0, N'(1) << w));
            for (int c = 0; c < 2*n*h; c++) led_exp[t+c] = ((c / h) % 2 == 0);
            for (int c = t; c < d; c++) busy_exp[c] = 1'b1;
            exp_q.push_back(mk_ev(d, 1'b1, N'(1) << w));
            if (!sc_hold) begin
               pend[w] = 1'b0;
               drop_cyc_q.push_back(t);
               drop_clr_q.push_back(N'(1) << w);
            end else if (k == lim - 1) begin
               drop_cyc_q.push_back(t);
               drop_clr_q.push_back(sc_mask);
            end
            m_free = d;
            t = d + 1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_sc(input logic [N-1:0] mask, input int c0, input int c1, input int c2,
                         input int c3, input int hp, input bit hold, input int ngr);
      sc_mask = mask; sc_cnt[0] = c0; sc_cnt[1] = c1; sc_cnt[2] = c2; sc_cnt[3] = c3;
      sc_hp = hp; sc_hold = hold; sc_ngr = ngr;
   endtask

   task automatic issue_sc(input int gap);
      while (cyc < m_free) @(negedge clk);
      repeat (gap) @(negedge clk);
      plan(cyc);
      for (int i = 0; i < N; i++) blinks_i[i*BW +: BW] = BW'(sc_cnt[i]);
      half_period_i = CW'(sc_hp);
      req_i = sc_mask;
   endtask

   // Release each request at its predicted grant cycle and scramble its count.
   task automatic finish_sc();
      int dc;
      logic [N-1:0] clr;
      while (drop_cyc_q.size() > 0) begin
         dc  = drop_cyc_q.pop_front();
         clr = drop_clr_q.pop_front();
         while (cyc < dc) @(negedge clk);
         req_i = req_i & ~clr;
         for (int i = 0; i < N; i++)
            if (clr[i]) blinks_i[i*BW +: BW] = BW'($urandom_range(0, 15));
      end
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   task automatic monitor();
      logic [EV_W-1:0] act, ex;
      forever begin
         @(negedge clk);
         if (cyc < MAXC) begin
            check_val("led", int'(led_o), int'(led_exp[cyc]));
            check_val("busy", int'(busy_o), int'(busy_exp[cyc]));
         end
         while (exp_q.size() > 0) begin
            ex = exp_q[0];
            if (int'(ex[36:5]) < cyc) begin
               checks++; failures++;
               $display("FAIL event_missing cyc=%0d exp_cyc=%0d exp_done=%0b exp_vec=%b",
                        cyc, ex[36:5], ex[4], ex[3:0]);
               void'(exp_q.pop_front());
            end else break;
         end
         if (grant_o != '0 || done_o != '0) begin
            act = mk_ev(cyc, done_o != '0, (done_o != '0) ? done_o : grant_o);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL event_unexpected cyc=%0d grant=%b done=%b", cyc, grant_o, done_o);
            end else begin
               ex = exp_q.pop_front();
               if (act !== ex) begin
                  failures++;
                  $display("FAIL event cyc=%0d got_done=%0b got_vec=%b exp_cyc=%0d exp_done=%0b exp_vec=%b",
                           cyc, act[4], act[3:0], ex[36:5], ex[4], ex[3:0]);
               end
            end
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int g;
      for (int c = 0; c < MAXC; c++) begin led_exp[c] = 1'b0; busy_exp[c] = 1'b0; end
      arstn = 1'b0; req_i = '0; blinks_i = '0; half_period_i = '0;
      m_last = N - 1; m_free = 0;
      fork monitor(); join_none
      repeat (3) @(negedge clk);
      check_val("rst_led", int'(led_o), 0);
      check_val("rst_busy", int'(busy_o), 0);
      check_val("rst_grant", int'(grant_o), 0);
      check_val("rst_done", int'(done_o), 0);
      check_val("rst_state", int'(dbg_state_o), int'(ST_IDLE));
      arstn = 1'b1;
      m_free = cyc;

      // Single request, 3 blinks, H=3.
      set_sc(4'b0001, 3, 0, 0, 0, 2, 1'b0, 1); issue_sc(1); finish_sc();
      // Round robin with all requests held, five grants.
      set_sc(4'b1111, 1, 1, 1, 1, 0, 1'b1, 5); issue_sc(2); finish_sc();
      // Zero-count burst.
      set_sc(4'b0100, 5, 5, 0, 5, 3, 1'b0, 1); issue_sc(0); finish_sc();
      // Maximum half-period at CNT_WIDTH=4.
      set_sc(4'b1000, 0, 0, 0, 2, 15, 1'b0, 1); issue_sc(3); finish_sc();
      set_sc(4'b0010, 0, 0, 0, 0, 15, 1'b0, 1); issue_sc(0); finish_sc();
      // Half-period change mid-burst must not stretch later phases.
      set_sc(4'b0001, 2, 0, 0, 0, 4, 1'b0, 1); issue_sc(1);
      g = drop_cyc_q[0];
      while (cyc < g + 2) @(negedge clk);
      half_period_i = CW'(9);
      finish_sc();

      // Randomized scenarios.
      for (int s = 0; s < 24; s++) begin
         set_sc(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                bit'($urandom_range(0, 1)), $urandom_range(1, 6));
         issue_sc($urandom_range(0, 3));
         finish_sc();
      end

      // Reset during OFF of a 5-blink burst.
      set_sc(4'b0001, 5, 0, 0, 0, 2, 1'b0, 1); issue_sc(1);
      g = drop_cyc_q[0];
      while (cyc < g + 4) @(negedge clk);
      req_i = '0;
      #2 arstn = 1'b0;
      #1;
      check_val("arst_led", int'(led_o), 0);
      check_val("arst_busy", int'(busy_o), 0);
      check_val("arst_grant", int'(grant_o), 0);
      check_val("arst_done", int'(done_o), 0);
      exp_q.delete(); drop_cyc_q.delete(); drop_clr_q.delete();
      for (int c = cyc + 1; c < MAXC; c++) begin led_exp[c] = 1'b0; busy_exp[c] = 1'b0; end
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      m_last = N - 1;
      m_free = cyc;
      set_sc(4'b1010, 0, $urandom_range(1, 3), 0, $urandom_range(0, 3), 1, 1'b0, 1);
      issue_sc(1); finish_sc();

      while (cyc < m_free + 3) @(negedge clk);
      check_val("events_left", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
